lion_airlock_ctrl: RTL
======================

LION_AIRLOCK_CTRL -- requirements
Module: lion_airlock_ctrl

Interface
REQ-001 SHALL use clock clk; reset reset, synchronous, active-high.
REQ-002 SHALL have parameter OPEN_CYCLES, default 8, meaning minimum cycles a door stays open (1..65535).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, meaning both-doors-closed interval between door phases (1..65535).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning open-phase cycles (counted from phase entry) after which alarm sets (> OPEN_CYCLES).
REQ-005 SHALL have ports, one per line:
  clk  in  1  clock
  reset  in  1  synchronous active-high reset
  req_entry  in  1  level request: move a lion outside->inside
  req_exit  in  1  level request: move a lion inside->outside
  occupied  in  1  passage light barrier; 1 = something in doorway
  lion_count  in  4  current lions in cage (0..15)
  alarm_ack  in  1  clears alarm
  door_outer  out  1  1 = outer door open
  door_inner  out  1  1 = inner door open
  busy  out  1  1 = transfer in progress
  grant_entry  out  1  one-cycle pulse on entry grant
  grant_exit  out  1  one-cycle pulse on exit grant
  done  out  1  one-cycle pulse when transfer completes
  alarm  out  1  sticky doorway-blocked alarm

Function
REQ-006 SHALL implement FSM states IDLE, OPEN1, SETTLE1, OPEN2, SETTLE2, plus a registered direction bit dir (0 = entry, 1 = exit).
REQ-007 In IDLE, entry eligible iff req_entry=1 and lion_count!=15; exit eligible iff req_exit=1 and lion_count!=0; ineligible requests ignored, no grant.
REQ-008 One eligible request: grant it; both eligible: grant per round-robin pointer rr (0 favours entry), rr resets to 0 and flips to the non-granted direction after each grant.
REQ-009 Grant cycle: grant_entry or grant_exit pulses high one cycle, dir latched, next state OPEN1.
REQ-010 Phase door mapping: entry OPEN1 = outer, OPEN2 = inner; exit OPEN1 = inner, OPEN2 = outer.
REQ-011 door_outer/door_inner SHALL be registered, high exactly for the cycles the FSM is in the matching OPEN state; never both high in any cycle.
REQ-012 OPEN state: 16-bit timer loaded OPEN_CYCLES-1 on entry, decrements to 0 and holds; exit to next state when timer==0 and occupied==0; otherwise remain (door held open).
REQ-013 SETTLE state lasts exactly SETTLE_CYCLES cycles, both doors closed; SETTLE1 -> OPEN2, SETTLE2 -> IDLE.
REQ-014 done SHALL pulse high one cycle on the first IDLE cycle after SETTLE2; busy high in every non-IDLE state.
REQ-015 Second 16-bit counter counts cycles in current OPEN state, saturating; when it reaches TIMEOUT_CYCLES, alarm sets; FSM keeps door open and continues normally.
REQ-016 alarm cleared only by alarm_ack=1 in a cycle where the timeout condition is not being met; ack and set in same cycle -> set wins.
REQ-017 Requests and lion_count changes during a transfer SHALL NOT alter the sequence; sampled only in IDLE.
REQ-018 Grant may occur in the same cycle done is asserted (back-to-back transfers).

Reset
REQ-019 On reset: state IDLE, dir 0, rr 0, timers 0, all outputs 0 next cycle; reset mid-transfer closes both doors immediately.

Verification
REQ-020 OPEN=4, SETTLE=2; req_entry pulse held, count=3, occupied=0, grant at t -> door_outer t+1..t+4, closed t+5..t+6, door_inner t+7..t+10, closed t+11..t+12, done at t+13, busy t+1..t+12.
REQ-021 Both requests held, count=5 -> grants alternate entry, exit, entry; done then next grant same cycle.
REQ-022 count=15 req_entry only -> no grant, doors closed; count=0 req_exit only -> no grant.
REQ-023 OPEN=4, TIMEOUT=10; occupied=1 through OPEN1 for 12 cycles -> door stays open, alarm rises 10 cycles after phase entry, sequence resumes when occupied=0; alarm_ack clears it.
REQ-024 Reset asserted during OPEN2 -> next cycle both doors 0, busy 0, IDLE; no done pulse.
REQ-025 Random stimulus checker: door_outer & door_inner never both 1.

Source files
------------

// File: rtl/lion_airlock_ctrl.sv
// Two-door lion airlock sequencer: grants entry/exit transfers, walks the
// outer/inner doors through open and settle phases, and raises a sticky alarm.
module lion_airlock_ctrl #(
    parameter int OPEN_CYCLES    = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_entry,
    input  logic       req_exit,
    input  logic       occupied,
    input  logic [3:0] lion_count,
    input  logic       alarm_ack,
    output logic       door_outer,
    output logic       door_inner,
    output logic       busy,
    output logic       grant_entry,
    output logic       grant_exit,
    output logic       done,
    output logic       alarm
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_OPEN1   = 3'd1;
    localparam logic [2:0] S_SETTLE1 = 3'd2;
    localparam logic [2:0] S_OPEN2   = 3'd3;
    localparam logic [2:0] S_SETTLE2 = 3'd4;

    localparam logic [15:0] OPEN_LOAD   = 16'(OPEN_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

    logic [2:0]  state_reg, state_next;
    logic        dir_reg, dir_next;
    logic        rr_reg, rr_next;
    logic [15:0] timer_reg, timer_next;
    logic [15:0] open_cnt_reg, open_cnt_next;
    logic        door_outer_reg, door_outer_next;
    logic        door_inner_reg, door_inner_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        alarm_reg, alarm_next;

    logic elig_entry, elig_exit;
    logic take_entry, take_exit;
    logic in_open, timeout_hit;

    // Requests are only looked at while idle; reset masks the combinational grant.
    always_comb begin
        elig_entry = req_entry && (lion_count != 4'd15);
        elig_exit  = req_exit && (lion_count != 4'd0);
        take_entry = 1'b0;
        take_exit  = 1'b0;
        if (state_reg == S_IDLE && !reset) begin
            if (elig_entry && elig_exit) begin
                take_entry = !rr_reg;
                take_exit  = rr_reg;
            end else begin
                take_entry = elig_entry;
                take_exit  = elig_exit;
            end
        end
    end

    assign in_open     = (state_reg == S_OPEN1) || (state_reg == S_OPEN2);
    assign timeout_hit = in_open && (open_cnt_reg >= TIMEOUT_VAL);

    always_comb begin
        state_next    = state_reg;
        dir_next      = dir_reg;
        rr_next       = rr_reg;
        timer_next    = timer_reg;
        open_cnt_next = open_cnt_reg;
        done_next     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (take_entry || take_exit) begin
                    state_next    = S_OPEN1;
                    dir_next      = take_exit;
                    rr_next       = take_entry;
                    timer_next    = OPEN_LOAD;
                    open_cnt_next = 16'd1;
                end
            end
            S_OPEN1, S_OPEN2: begin
                open_cnt_next = (open_cnt_reg == 16'hFFFF) ? open_cnt_reg : open_cnt_reg + 16'd1;
                if (timer_reg == 16'd0) begin
                    // Door stays open as long as the light barrier is interrupted.
                    if (!occupied) begin
                        state_next = (state_reg == S_OPEN1) ? S_SETTLE1 : S_SETTLE2;
                        timer_next = SETTLE_LOAD;
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
            S_SETTLE1: begin
                if (timer_reg == 16'd0) begin
                    state_next    = S_OPEN2;
                    timer_next    = OPEN_LOAD;
                    open_cnt_next = 16'd1;
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
            S_SETTLE2: begin
                if (timer_reg == 16'd0) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Doors derive from the next state so they track the OPEN states cycle-for-cycle.
    always_comb begin
        door_outer_next = ((state_next == S_OPEN1) && !dir_next) || ((state_next == S_OPEN2) && dir_next);
        door_inner_next = ((state_next == S_OPEN1) && dir_next) || ((state_next == S_OPEN2) && !dir_next);
        busy_next       = (state_next != S_IDLE);
        alarm_next      = timeout_hit ? 1'b1 : (alarm_ack ? 1'b0 : alarm_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            dir_reg        <= 1'b0;
            rr_reg         <= 1'b0;
            timer_reg      <= 16'd0;
            open_cnt_reg   <= 16'd0;
            door_outer_reg <= 1'b0;
            door_inner_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            alarm_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dir_reg        <= dir_next;
            rr_reg         <= rr_next;
            timer_reg      <= timer_next;
            open_cnt_reg   <= open_cnt_next;
            door_outer_reg <= door_outer_next;
            door_inner_reg <= door_inner_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            alarm_reg      <= alarm_next;
        end
    end

    assign door_outer  = door_outer_reg;
    assign door_inner  = door_inner_reg;
    assign busy        = busy_reg;
    assign grant_entry = take_entry;
    assign grant_exit  = take_exit;
    assign done        = done_reg;
    assign alarm       = alarm_reg;

endmodule
